tcm_mem_loader: RTL

Write-side loader for the 128 KB tightly-coupled memory: accepts a framed byte stream (debug UART or boot SPI bridge), assembles little-endian 64-bit words and issues full-word writes into the TCM's 14-bit word-addressed array. It sits between the boot/debug byte source and the TCM write port, complementing the dual read ports used by fetch and load paths. It runs from reset and is intended to populate instruction/data memory before the core is released.

---
 rtl/tcm_mem_loader_pkg.sv | 37 +++
 rtl/tcm_mem_loader_asm.sv | 41 ++++
 rtl/tcm_mem_loader.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/tcm_mem_loader_pkg.sv
// tcm_mem_loader_pkg
// Shared types and constants for the TCM write-side loader.
// Contents: TCM geometry, default frame sync byte, header byte positions
// and the loader state enum. The CSUM state exists only when
// TCM_MEM_LOADER_CHECKSUM_EN is defined.
package tcm_mem_loader_pkg;

   localparam int TCM_ADDR_W     = 14;
   localparam int TCM_DATA_W     = 64;
   localparam int BYTES_PER_WORD = 8;

   localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

   // Byte positions within the frame header
   localparam int HDR_SYNC    = 0;
   localparam int HDR_ADDR_LO = 1;
   localparam int HDR_ADDR_HI = 2;
   localparam int HDR_LEN_LO  = 3;
   localparam int HDR_LEN_HI  = 4;
   localparam int HDR_BYTES   = 5;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ADDR0 = 3'd1,
      ST_ADDR1 = 3'd2,
      ST_LEN0  = 3'd3,
      ST_LEN1  = 3'd4,
      ST_DATA  = 3'd5,
`ifdef TCM_MEM_LOADER_CHECKSUM_EN
      ST_WRITE = 3'd6,
      ST_CSUM  = 3'd7
`else
      ST_WRITE = 3'd6
`endif
   } state_e;

endpackage

// File: rtl/tcm_mem_loader_asm.sv
// tcm_mem_loader_asm
// Byte-lane assembler: packs consecutive bytes little-endian into a 64-bit
// word. Lane counter wraps after byte 7, so the next word starts at lane 0.
// Ports:
//   clk_i, rst_ni   clock, async active-low reset
//   clear_i         restart at lane 0 with an all-zero word
//   load_i, byte_i  store byte_i into the current lane and advance
//   word_o          assembled word
//   word_full_o     high in the cycle the byte for lane 7 is loaded
module tcm_mem_loader_asm
   import tcm_mem_loader_pkg::*;
(
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  clear_i,
   input  logic                  load_i,
   input  logic [7:0]            byte_i,
   output logic [TCM_DATA_W-1:0] word_o,
   output logic                  word_full_o
);

   logic [2:0]            lane_q;
   logic [TCM_DATA_W-1:0] word_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         lane_q <= 3'd0;
         word_q <= '0;
      end else if (clear_i) begin
         lane_q <= 3'd0;
         word_q <= '0;
      end else if (load_i) begin
         lane_q                      <= lane_q + 3'd1;
         word_q[{lane_q, 3'b000} +: 8] <= byte_i;
      end
   end

   assign word_o      = word_q;
   assign word_full_o = load_i && (lane_q == 3'd7);

endmodule

// File: rtl/tcm_mem_loader.sv
// tcm_mem_loader
// Parses a framed byte stream (SYNC, ADDR_LO, ADDR_HI, LEN_LO, LEN_HI,
// LEN x 8 data bytes[, checksum]) and issues full 64-bit writes to the TCM.
// Build option: TCM_MEM_LOADER_CHECKSUM_EN adds a trailing checksum byte
// (8-bit sum of every byte after SYNC) and a sticky error_o.
// Ports:
//   clk_i, rst_ni              clock, async active-low reset
//   in_valid_i/in_data_i/in_ready_o   byte stream handshake
//   mem_wr_o/mem_addr_o/mem_data_o    TCM write request, held until mem_accept_i
//   mem_accept_i               TCM takes the write this cycle
//   busy_o                     frame in progress
//   done_o                     one-cycle pulse in the IDLE cycle after frame end
//   error_o                    sticky checksum mismatch (0 without checksum)
//
// state  | meaning
// IDLE   | hunting for SYNC_BYTE, other bytes dropped
// ADDR0  | expecting address low byte
// ADDR1  | expecting address high byte (bits 7:6 ignored)
// LEN0   | expecting word count low byte
// LEN1   | expecting word count high byte
// DATA   | collecting 8 data bytes into the assembler
// WRITE  | write request pending on the TCM port, stream stalled
// CSUM   | expecting checksum byte (checksum builds only)
module tcm_mem_loader
   import tcm_mem_loader_pkg::*;
#(
   parameter int         ADDR_W    = TCM_ADDR_W,
   parameter int         DATA_W    = TCM_DATA_W,
   parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              in_valid_i,
   input  logic [7:0]        in_data_i,
   output logic              in_ready_o,
   output logic              mem_wr_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_data_o,
   input  logic              mem_accept_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              error_o
);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [15:0]       len_q, len_d;
   logic              done_q, done_d;
   logic              ready_q;
   logic              hs;
   logic              sync_hs;
   logic              asm_clear, asm_load, word_full;

   // Holds in_ready_o low while in reset and for the first edge out of it.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) ready_q <= 1'b0;
      else         ready_q <= 1'b1;
   end

   assign in_ready_o = ready_q && (state_q != ST_WRITE);
   assign hs         = in_valid_i && in_ready_o;
   assign sync_hs    = hs && (state_q == ST_IDLE) && (in_data_i == SYNC_BYTE);

   tcm_mem_loader_asm u_asm (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .clear_i     (asm_clear),
      .load_i      (asm_load),
      .byte_i      (in_data_i),
      .word_o      (mem_data_o),
      .word_full_o (word_full)
   );

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      len_d     = len_q;
      done_d    = 1'b0;
      asm_clear = 1'b0;
      asm_load  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (sync_hs) begin
               asm_clear = 1'b1;
               state_d   = ST_ADDR0;
            end
         end
         ST_ADDR0: begin
            if (hs) begin
               addr_d[7:0] = in_data_i;
               state_d     = ST_ADDR1;
            end
         end
         ST_ADDR1: begin
            if (hs) begin
               addr_d[ADDR_W-1:8] = in_data_i[ADDR_W-9:0];
               state_d            = ST_LEN0;
            end
         end
         ST_LEN0: begin
            if (hs) begin
               len_d[7:0] = in_data_i;
               state_d    = ST_LEN1;
            end
         end
         ST_LEN1: begin
            if (hs) begin
               len_d[15:8] = in_data_i;
               if ({in_data_i, len_q[7:0]} == 16'd0) begin
`ifdef TCM_MEM_LOADER_CHECKSUM_EN
                  state_d = ST_CSUM;
`else
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
`endif
               end else begin
                  state_d = ST_DATA;
               end
            end
         end
         ST_DATA: begin
            if (hs) begin
               asm_load = 1'b1;
               if (word_full) state_d = ST_WRITE;
            end
         end
         ST_WRITE: begin
            if (mem_accept_i) begin
               addr_d = addr_q + ADDR_W'(1);
               len_d  = len_q - 16'd1;
               if (len_q == 16'd1) begin
`ifdef TCM_MEM_LOADER_CHECKSUM_EN
                  state_d = ST_CSUM;
`else
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
`endif
               end else begin
                  state_d = ST_DATA;
               end
            end
         end
`ifdef TCM_MEM_LOADER_CHECKSUM_EN
         ST_CSUM: begin
            if (hs) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
`endif
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         len_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         len_q   <= len_d;
         done_q  <= done_d;
      end
   end

`ifdef TCM_MEM_LOADER_CHECKSUM_EN
   logic [7:0] sum_q, sum_d;
   logic       err_q, err_d;

   always_comb begin
      sum_d = sum_q;
      err_d = err_q;
      if (sync_hs) begin
         sum_d = 8'd0;
         err_d = 1'b0;
      end else if (hs && (state_q == ST_CSUM)) begin
         if (in_data_i != sum_q) err_d = 1'b1;
      end else if (hs && (state_q != ST_IDLE)) begin
         sum_d = sum_q + in_data_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sum_q <= 8'd0;
         err_q <= 1'b0;
      end else begin
         sum_q <= sum_d;
         err_q <= err_d;
      end
   end

   assign error_o = err_q;
`else
   assign error_o = 1'b0;
`endif

   assign mem_wr_o   = (state_q == ST_WRITE);
   assign mem_addr_o = addr_q;
   assign busy_o     = (state_q != ST_IDLE);
   assign done_o     = done_q;

endmodule
